// File: rtl/axi_pkg.sv
// Shared AXI4-Lite response encoding and protection constant for the data memory.
package axi_pkg;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExOkay = 2'b01,
    RespSlvErr = 2'b10,
    RespDecErr = 2'b11
  } axi_resp_e;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/data_mem_axil_dm_ram.sv
// Word RAM: one byte-enabled write port, one synchronous read port.
// A read and write to the same word at one edge returns the old word.
module dm_ram #(
  parameter int XLEN  = 32,
  parameter int STRB  = XLEN / 8,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_widx,
  input  logic [XLEN-1:0]          i_wdata,
  input  logic [STRB-1:0]          i_wstrb,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_ridx,
  output logic [XLEN-1:0]          o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rdata;

  // Non-blocking update of r_mem makes a same-edge read see the pre-write word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < STRB; b++) begin
        if (i_wstrb[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_ridx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_axil.sv
// AXI4-Lite slave data memory: pipelined 1-cycle read path and an
// independent AW/W join FSM that commits byte-strobed stores into dm_ram.
module data_mem_axil
  import axi_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int STRB  = XLEN / 8,
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_arvalid,
  output logic            o_arready,
  input  logic [XLEN-1:0] i_araddr,
  input  logic [2:0]      i_arprot,
  output logic            o_rvalid,
  input  logic            i_rready,
  output logic [XLEN-1:0] o_rdata,
  output logic [1:0]      o_rresp,
  input  logic            i_awvalid,
  output logic            o_awready,
  input  logic [XLEN-1:0] i_awaddr,
  input  logic [2:0]      i_awprot,
  input  logic            i_wvalid,
  output logic            o_wready,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [STRB-1:0] i_wstrb,
  output logic            o_bvalid,
  input  logic            i_bready,
  output logic [1:0]      o_bresp,
  output logic [1:0]      o_wr_state
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int OFFW = $clog2(STRB);
  localparam logic [XLEN-1:0] LIMIT = XLEN'(DEPTH * STRB);

  // Write FSM encoding: bit0 = AW held, bit1 = W held, both = response pending.
  localparam logic [1:0] WR_IDLE    = 2'd0;
  localparam logic [1:0] WR_HAVE_AW = 2'd1;
  localparam logic [1:0] WR_HAVE_W  = 2'd2;
  localparam logic [1:0] WR_RESP    = 2'd3;

  logic            w_unused;
  assign w_unused = ^{i_arprot, i_awprot};

  // ---------------- read path ----------------
  logic            r_rvalid;
  logic            r_rd_ok;
  axi_resp_e       r_rresp;
  logic            w_ar_hs;
  logic            w_ar_ok;
  logic [XLEN-1:0] w_ram_q;

  assign o_arready = !r_rvalid || i_rready;
  assign w_ar_hs   = i_arvalid && o_arready;
  assign w_ar_ok   = i_araddr < LIMIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rd_ok  <= 1'b0;
      r_rresp  <= RespOkay;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rd_ok  <= w_ar_ok;
      r_rresp  <= w_ar_ok ? RespOkay : RespDecErr;
    end else if (i_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // RAM output only advances on an AR handshake, so gating it holds rdata stable.
  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rd_ok ? w_ram_q : '0;
  assign o_rresp  = r_rresp;

  // ---------------- write path ----------------
  logic [1:0]      r_wstate;
  logic [XLEN-1:0] r_awaddr;
  logic [XLEN-1:0] r_wdata;
  logic [STRB-1:0] r_wstrb;
  axi_resp_e       r_bresp;
  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_aw_avail;
  logic            w_w_avail;
  logic            w_commit;
  logic            w_wr_ok;
  logic [XLEN-1:0] w_cm_addr;
  logic [XLEN-1:0] w_cm_data;
  logic [STRB-1:0] w_cm_strb;

  assign o_awready = (r_wstate == WR_IDLE) || (r_wstate == WR_HAVE_W);
  assign o_wready  = (r_wstate == WR_IDLE) || (r_wstate == WR_HAVE_AW);
  assign o_bvalid  = (r_wstate == WR_RESP);
  assign o_bresp   = r_bresp;
  assign o_wr_state = r_wstate;

  assign w_aw_hs    = i_awvalid && o_awready;
  assign w_w_hs     = i_wvalid && o_wready;
  assign w_aw_avail = w_aw_hs || (r_wstate == WR_HAVE_AW);
  assign w_w_avail  = w_w_hs || (r_wstate == WR_HAVE_W);
  assign w_commit   = w_aw_avail && w_w_avail;

  assign w_cm_addr = (r_wstate == WR_HAVE_AW) ? r_awaddr : i_awaddr;
  assign w_cm_data = (r_wstate == WR_HAVE_W) ? r_wdata : i_wdata;
  assign w_cm_strb = (r_wstate == WR_HAVE_W) ? r_wstrb : i_wstrb;
  assign w_wr_ok   = w_cm_addr < LIMIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= WR_IDLE;
      r_bresp  <= RespOkay;
    end else begin
      case (r_wstate)
        WR_RESP: if (i_bready) r_wstate <= WR_IDLE;
        default: begin
          if (w_commit) begin
            r_wstate <= WR_RESP;
            r_bresp  <= w_wr_ok ? RespOkay : RespDecErr;
          end else if (w_aw_hs) begin
            r_wstate <= WR_HAVE_AW;
          end else if (w_w_hs) begin
            r_wstate <= WR_HAVE_W;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_aw_hs) r_awaddr <= i_awaddr;
    if (w_w_hs) begin
      r_wdata <= i_wdata;
      r_wstrb <= i_wstrb;
    end
  end

  dm_ram #(
    .XLEN (XLEN),
    .STRB (STRB),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_commit && w_wr_ok),
    .i_widx (w_cm_addr[OFFW +: IDXW]),
    .i_wdata(w_cm_data),
    .i_wstrb(w_cm_strb),
    .i_re   (w_ar_hs),
    .i_ridx (i_araddr[OFFW +: IDXW]),
    .o_rdata(w_ram_q)
  );

endmodule

// File: tb/tb_data_mem_axil.sv
// Directed plus randomized bench for data_mem_axil against a word-array memory model.
module tb_data_mem_axil;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_arvalid = 1'b0, i_rready = 1'b0;
  logic        i_awvalid = 1'b0, i_wvalid = 1'b0, i_bready = 1'b0;
  logic [31:0] i_araddr = '0, i_awaddr = '0, i_wdata = '0;
  logic [3:0]  i_wstrb = '0;
  logic        o_arready, o_rvalid, o_awready, o_wready, o_bvalid;
  logic [31:0] o_rdata;
  logic [1:0]  o_rresp, o_bresp, o_wr_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl   [1024];
  bit          known [1024];

  data_mem_axil dut (
    .clk(clk), .rst(rst),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr), .i_arprot(AXI_PROT_DEFAULT),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata), .o_rresp(o_rresp),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr), .i_awprot(AXI_PROT_DEFAULT),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp), .o_wr_state(o_wr_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit oor(input logic [31:0] a);
    return a >= 32'h1000;
  endfunction

  function automatic logic [31:0] exp_resp(input logic [31:0] a);
    return oor(a) ? 32'(RespDecErr) : 32'(RespOkay);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!oor(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[a[11:2]][8*b +: 8] = d[8*b +: 8];
      if (s == 4'hF) known[a[11:2]] = 1'b1;
    end
  endtask

  // mode 0: AW and W together; 1: W first then AW after gap; 2: AW first then W after gap.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int mode, input int gap);
    @(negedge clk);
    check("wr_idle_awready", o_awready, 1);
    check("wr_idle_wready", o_wready, 1);
    i_awaddr = a; i_wdata = d; i_wstrb = s;
    if (mode == 0) begin
      i_awvalid = 1; i_wvalid = 1;
      @(negedge clk);
      i_awvalid = 0; i_wvalid = 0;
    end else if (mode == 1) begin
      i_wvalid = 1;
      @(negedge clk);
      i_wvalid = 0;
      repeat (gap) begin
        check("have_w_wready", o_wready, 0);
        check("have_w_awready", o_awready, 1);
        check("have_w_bvalid", o_bvalid, 0);
        @(negedge clk);
      end
      i_awvalid = 1;
      @(negedge clk);
      i_awvalid = 0;
    end else begin
      i_awvalid = 1;
      @(negedge clk);
      i_awvalid = 0;
      repeat (gap) begin
        check("have_aw_awready", o_awready, 0);
        check("have_aw_wready", o_wready, 1);
        check("have_aw_bvalid", o_bvalid, 0);
        @(negedge clk);
      end
      i_wvalid = 1;
      @(negedge clk);
      i_wvalid = 0;
    end
    model_write(a, d, s);
    check("b_valid", o_bvalid, 1);
    check("b_resp", o_bresp, exp_resp(a));
    check("resp_awready", o_awready, 0);
    i_bready = 1;
    @(negedge clk);
    i_bready = 0;
    check("b_done", o_bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    logic [31:0] e;
    bit          chk;
    e   = oor(a) ? 32'h0 : mdl[a[11:2]];
    chk = oor(a) || known[a[11:2]];
    @(negedge clk);
    check("rd_arready", o_arready, 1);
    i_arvalid = 1; i_araddr = a; i_rready = 0;
    @(negedge clk);
    i_arvalid = 0;
    check("rd_rvalid", o_rvalid, 1);
    check("rd_rresp", o_rresp, exp_resp(a));
    if (chk) check("rd_rdata", o_rdata, e);
    repeat (hold) begin
      @(negedge clk);
      check("rd_hold_rvalid", o_rvalid, 1);
      check("rd_hold_arready", o_arready, 0);
      if (chk) check("rd_hold_rdata", o_rdata, e);
    end
    i_rready = 1;
    @(negedge clk);
    i_rready = 0;
    check("rd_done_rvalid", o_rvalid, 0);
  endtask

  initial begin
    logic [31:0] a, d, old;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;

    // reset state
    check("rst_rvalid", o_rvalid, 0);
    check("rst_bvalid", o_bvalid, 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_rresp", o_rresp, 0);
    check("rst_awready", o_awready, 1);
    check("rst_wready", o_wready, 1);
    check("rst_arready", o_arready, 1);

    // give the first 16 words known contents
    for (int i = 0; i < 16; i++) do_write(32'(i * 4), $urandom, 4'hF, 0, 0);

    // same-cycle AW/W, then readback
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read(32'h10, 0);
    check("t1_model", mdl[4], 32'hDEADBEEF);

    // W first, AW three cycles later, single byte
    do_write(32'h10, 32'h000000AA, 4'h1, 1, 2);
    do_read(32'h10, 0);
    check("t2_model", mdl[4], 32'hDEADBEAA);

    // four back-to-back reads
    @(negedge clk);
    i_rready = 1;
    for (int i = 0; i < 4; i++) begin
      i_arvalid = 1; i_araddr = 32'(i * 4);
      check("b2b_arready", o_arready, 1);
      if (i > 0) begin
        check("b2b_rvalid", o_rvalid, 1);
        check("b2b_rdata", o_rdata, mdl[i-1]);
      end
      @(negedge clk);
    end
    i_arvalid = 0;
    check("b2b_last_rvalid", o_rvalid, 1);
    check("b2b_last_rdata", o_rdata, mdl[3]);
    @(negedge clk);
    i_rready = 0;
    check("b2b_end_rvalid", o_rvalid, 0);

    // R backpressure
    do_read(32'h8, 5);

    // out-of-range read and write
    do_read(32'h1000, 0);
    do_write(32'h1000, 32'h12345678, 4'hF, 0, 0);
    do_read(32'h0, 0);

    // zero strobe still responds OKAY and changes nothing
    do_write(32'h14, 32'hFFFFFFFF, 4'h0, 2, 1);
    do_read(32'h14, 0);

    // read-before-write collision on the same word
    @(negedge clk);
    a = 32'h20; old = mdl[8]; d = ~old;
    i_arvalid = 1; i_araddr = a; i_rready = 0;
    i_awvalid = 1; i_awaddr = a; i_wvalid = 1; i_wdata = d; i_wstrb = 4'hF;
    @(negedge clk);
    i_arvalid = 0; i_awvalid = 0; i_wvalid = 0;
    check("col_rvalid", o_rvalid, 1);
    check("col_rdata_old", o_rdata, old);
    check("col_bvalid", o_bvalid, 1);
    model_write(a, d, 4'hF);
    i_rready = 1; i_bready = 1;
    @(negedge clk);
    i_rready = 0; i_bready = 0;
    do_read(a, 0);

    // reset while an AW is held
    @(negedge clk);
    i_awvalid = 1; i_awaddr = 32'h44;
    @(negedge clk);
    i_awvalid = 0;
    check("pre_rst_awready", o_awready, 0);
    check("pre_rst_state", o_wr_state, 2'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("post_rst_bvalid", o_bvalid, 0);
    check("post_rst_awready", o_awready, 1);
    check("post_rst_wready", o_wready, 1);
    check("post_rst_state", o_wr_state, 2'd0);
    @(negedge clk);
    check("post_rst_bvalid2", o_bvalid, 0);
    do_write(32'h44, 32'hCAFEF00D, 4'hF, 0, 0);
    do_read(32'h44, 0);

    // randomized mix of reads and writes
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) a = 32'h1000 + ($urandom_range(0, 255) << 2);
      else a = ($urandom_range(0, 17) << 2) | $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: do_write(a, $urandom, 4'($urandom_range(0, 15)), 0, 0);
        1: do_write(a, $urandom, 4'($urandom_range(0, 15)), 1, $urandom_range(0, 3));
        2: do_write(a, $urandom, 4'($urandom_range(0, 15)), 2, $urandom_range(0, 3));
        default: do_read(a, $urandom_range(0, 2));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
